hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline.
- Compares ID-stage source registers against EX/MEM destinations and detects load-use and branch-in-ID operand hazards.
- Owns the shared multi-cycle mult/div resource through a busy/done FSM.
- Drives PC/IF-ID stall and the ID/EX bubble (flush) so that the ID stage, which resolves branches with MEM/WB forwarding only, always sees valid operands.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit is busy after issue (range 2..63)
CNT_W, 6, width of the mult/div countdown counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs  in  5  ID instr[25:21]
id_rt  in  5  ID instr[20:16]
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID instruction consumes operands in ID (branch, jr/jalr)
id_is_md  in  1  ID instruction issues mult/div
id_reads_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
ex_rw  in  5  EX-stage destination register
ex_regwrite  in  1  EX writes GPR
ex_memread  in  1  EX is a load
mem_rw  in  5  MEM-stage destination register
mem_regwrite  in  1  MEM writes GPR
mem_memread  in  1  MEM is a load
exc_flush  in  1  exception entry or eret resolved in ID
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
id_flush  out  1  zero the EX/MEM/WB control fields in ID/EX (bubble)
md_start  out  1  one-cycle issue pulse to the mult/div unit
md_done  out  1  one-cycle pulse when the HI/LO result is valid
md_busy  out  1  FSM not IDLE
stall_cause  out  3  {md, branch, loaduse} flags for the current cycle
stall_count  out  32  saturating count of stalled cycles

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous and active-high. Both are fixed.
- Match rules (combinational):
  - rs_ex = id_use_rs & ex_regwrite & (ex_rw==id_rs) & (id_rs!=0). rt_ex, rs_mem and rt_mem are defined the same way.
  - Register 0 never causes a hazard.
- loaduse = ex_memread & (rs_ex | rt_ex).
- branch = id_is_branch & ((rs_ex | rt_ex) | (mem_memread & (rs_mem | rt_mem))).
  - ALU results in MEM are forwarded, so they do not stall.
  - Load data is not available until WB.
- md = (id_is_md | id_reads_hilo) & (state != IDLE).
- stall = loaduse | branch | md. stall_cause = {md, branch, loaduse}.
- Priority: exc_flush overrides everything. When exc_flush=1:
  - pc_stall = 0, ifid_stall = 0, id_flush = 1, md_start = 0.
  - stall_cause = 0.
- Otherwise:
  - pc_stall = ifid_stall = stall.
  - id_flush = stall.
  - md_start = id_is_md & ~stall & (state==IDLE).
- FSM, registered, three states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on md_start; the counter loads MD_LATENCY-1.
  - BUSY: the counter decrements each cycle; at count==0 the FSM moves to DONE.
  - DONE lasts exactly one cycle: md_done=1, then the FSM returns to IDLE.
  - md_done is 1 only in DONE.
  - ID instructions that are md or hilo readers stall in both BUSY and DONE, and proceed in the following IDLE cycle.
  - md_busy = (state != IDLE).
  - An md instruction already issued is never aborted by exc_flush.
- Latency: all stall/flush outputs are combinational, same cycle as the inputs. Between md_start and md_done there are exactly MD_LATENCY cycles.
- stall_count: increments by 1 on every cycle with pc_stall=1, and saturates at 0xFFFFFFFF.
- Reset, including mid-operation:
  - state = IDLE, counter = 0, stall_count = 0.
  - While rst=1: pc_stall = ifid_stall = md_start = 0, id_flush = 1, md_done = 0, md_busy = 0, stall_cause = 0.
- Simultaneous events:
  - loaduse and branch together: a single stall, with both cause bits set.
  - id_is_md in the same cycle as DONE: stall, then issue on the next cycle.

Test Plan:
1. Load-use: ex_memread=1, ex_regwrite=1, ex_rw=8; ID id_rs=8, id_use_rs=1 -> pc_stall=ifid_stall=id_flush=1 and stall_cause=3'b001 for one cycle. Next cycle with the EX inputs cleared -> all 0; stall_count=1.
2. Branch hazards:
   - id_is_branch=1, id_rt=9, ex_rw=9, ex_regwrite=1, ex_memread=0 -> stall, cause=3'b010.
   - Same with the producer in MEM and mem_memread=0 -> no stall.
   - Same with mem_memread=1 -> stall.
3. Register 0: id_rs=0 with ex_rw=0, ex_memread=1 -> no stall.
4. Mult/div with MD_LATENCY=4: id_is_md pulse at cycle t -> md_start at t; md_busy for t+1..t+4; md_done only at t+4. id_reads_hilo held from t+1 -> stalled through t+4, released at t+5.
5. Flush priority: exc_flush=1 together with a load-use hazard -> pc_stall=0, id_flush=1, stall_cause=0, stall_count unchanged.
6. Reset mid-op: rst=1 while BUSY with count=2 -> the next cycle state=IDLE, md_busy=0, stall_count=0, and md_done never pulses.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX/MEM register info in,
// stall/flush/mult-div control out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_is_branch;
  logic        id_is_md;
  logic        id_reads_hilo;
  logic [4:0]  ex_rw;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  mem_rw;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        exc_flush;
  logic        pc_stall;
  logic        ifid_stall;
  logic        id_flush;
  logic        md_start;
  logic        md_done;
  logic        md_busy;
  logic [2:0]  stall_cause;
  logic [31:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_is_md,
           id_reads_hilo, ex_rw, ex_regwrite, ex_memread, mem_rw,
           mem_regwrite, mem_memread, exc_flush,
    input  pc_stall, ifid_stall, id_flush, md_start, md_done, md_busy,
           stall_cause, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_is_md,
           id_reads_hilo, ex_rw, ex_regwrite, ex_memread, mem_rw,
           mem_regwrite, mem_memread, exc_flush,
    output pc_stall, ifid_stall, id_flush, md_start, md_done, md_busy,
           stall_cause, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use and branch-in-ID
// operand hazards plus ownership of the shared multi-cycle mult/div unit.
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_count_q;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic loaduse, branch, md, stall;
  logic md_issue, stall_active;

  assign rs_ex  = hz.id_use_rs & hz.ex_regwrite  & (hz.ex_rw  == hz.id_rs) & (hz.id_rs != 5'd0);
  assign rt_ex  = hz.id_use_rt & hz.ex_regwrite  & (hz.ex_rw  == hz.id_rt) & (hz.id_rt != 5'd0);
  assign rs_mem = hz.id_use_rs & hz.mem_regwrite & (hz.mem_rw == hz.id_rs) & (hz.id_rs != 5'd0);
  assign rt_mem = hz.id_use_rt & hz.mem_regwrite & (hz.mem_rw == hz.id_rt) & (hz.id_rt != 5'd0);

  // ID only has MEM/WB forwarding, so a branch waits on any EX producer and on MEM loads.
  assign loaduse = hz.ex_memread & (rs_ex | rt_ex);
  assign branch  = hz.id_is_branch & ((rs_ex | rt_ex) | (hz.mem_memread & (rs_mem | rt_mem)));
  assign md      = (hz.id_is_md | hz.id_reads_hilo) & (state_q != IDLE);
  assign stall   = loaduse | branch | md;

  assign md_issue     = hz.id_is_md & ~stall & (state_q == IDLE) & ~hz.exc_flush & ~rst;
  assign stall_active = stall & ~hz.exc_flush & ~rst;

  // Counter is loaded with MD_LATENCY-1 so DONE lands MD_LATENCY cycles after issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_issue) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hz.pc_stall    = 1'b0;
    hz.ifid_stall  = 1'b0;
    hz.id_flush    = 1'b0;
    hz.md_start    = 1'b0;
    hz.md_done     = 1'b0;
    hz.md_busy     = 1'b0;
    hz.stall_cause = 3'b000;
    if (rst) begin
      hz.id_flush = 1'b1;
    end else begin
      hz.md_done = (state_q == DONE);
      hz.md_busy = (state_q != IDLE);
      if (hz.exc_flush) begin
        hz.id_flush = 1'b1;
      end else begin
        hz.pc_stall    = stall;
        hz.ifid_stall  = stall;
        hz.id_flush    = stall;
        hz.md_start    = md_issue;
        hz.stall_cause = {md, branch, loaduse};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_active && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign hz.stall_count = stall_count_q;

endmodule
